// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    ERR       = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hard-wired to zero, so a write to it never produces a hazard.
  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_controller_forward_select.sv
// Per-operand forwarding comparator; the Memory stage has the newer value and wins.
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && reg_hit(rd_m, rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && reg_hit(rd_w, rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard/stall sequencer: forwarding selects, load-use and data-memory stalls,
// bounded memory-wait FSM with sticky timeout error, saturating perf counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             DMemReadyM,
  input  logic             ErrClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  mw_cnt_q, mw_cnt_d;

  logic lw_stall;
  logic mem_stall;

  forward_select u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardAE)
  );

  forward_select u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardBE)
  );

  assign lw_stall  = ResultSrcE0 && reg_hit(RdE, Rs1D | 5'd0) || ResultSrcE0 && reg_hit(RdE, Rs2D);
  assign mem_stall = ((state_q == RUN) && MemReqM && !DMemReadyM) ||
                     (state_q == DMEM_WAIT) || (state_q == ERR);

  // A memory stall freezes the whole pipe, so a pending redirect in E waits it out.
  always_comb begin
    StallF = lw_stall;
    StallD = lw_stall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = PCSrcE;
    FlushE = lw_stall | PCSrcE;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (MemReqM && !DMemReadyM) begin
          state_d    = DMEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      DMEM_WAIT: begin
        if (DMemReadyM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d    = ERR;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERR: begin
        if (ErrClr) begin
          state_d   = RUN;
          mem_err_d = 1'b0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    mw_cnt_d = mw_cnt_q;
    if (lw_stall && !mem_stall && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
    if (mem_stall && (state_q != ERR) && (mw_cnt_q != '1)) begin
      mw_cnt_d = mw_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      lu_cnt_q   <= '0;
      mw_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      lu_cnt_q   <= lu_cnt_d;
      mw_cnt_q   <= mw_cnt_d;
    end
  end

  assign MemErr     = mem_err_q;
  assign LoadUseCnt = lu_cnt_q;
  assign MemWaitCnt = mw_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: directed and random stimulus against a behavioural model.
module tb_hazard_controller;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic RegWriteM = 0, RegWriteW = 0, ResultSrcE0 = 0, PCSrcE = 0;
  logic MemReqM = 0, DMemReadyM = 0, ErrClr = 0;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CW-1:0] LoadUseCnt, MemWaitCnt;

  hazard_controller #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .DMemReadyM(DMemReadyM), .ErrClr(ErrClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .LoadUseCnt(LoadUseCnt), .MemWaitCnt(MemWaitCnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    bit rwm, rww, ld, pcsrc, memreq, rdy, errclr, rst;
  } stim_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic [6:0] sf;
    bit merr;
    int lu, mw, idx;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Model state: cycles spent waiting on memory (0 = not waiting), error flag, counters.
  int m_wait = 0;
  bit m_err = 0;
  int m_lu = 0;
  int m_mw = 0;
  int cyc = 0;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] rdm, input bit rwm,
                                         input logic [4:0] rdw, input bit rww);
    if (rwm && rdm != 0 && rdm == rs) return 2'b10;
    if (rww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rs1d = 0; s.rs2d = 0; s.rs1e = 0; s.rs2e = 0; s.rde = 0; s.rdm = 0; s.rdw = 0;
    s.rwm = 0; s.rww = 0; s.ld = 0; s.pcsrc = 0; s.memreq = 0; s.rdy = 0; s.errclr = 0; s.rst = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit lw, ms;
    @(negedge clk);
    reset = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; RegWriteM = s.rwm; RegWriteW = s.rww;
    ResultSrcE0 = s.ld; PCSrcE = s.pcsrc; MemReqM = s.memreq; DMemReadyM = s.rdy; ErrClr = s.errclr;
    if (s.rst) begin
      m_wait = 0; m_err = 0; m_lu = 0; m_mw = 0;
    end
    lw = s.ld && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    ms = m_err || (m_wait > 0) || (s.memreq && !s.rdy);
    e.fa = fwd_ref(s.rs1e, s.rdm, s.rwm, s.rdw, s.rww);
    e.fb = fwd_ref(s.rs2e, s.rdm, s.rwm, s.rdw, s.rww);
    // Bit order: StallF StallD StallE StallM FlushD FlushE FlushW
    if (ms) e.sf = 7'b1111001;
    else    e.sf = {lw, lw, 1'b0, 1'b0, s.pcsrc, lw | s.pcsrc, 1'b0};
    e.merr = m_err; e.lu = m_lu; e.mw = m_mw; e.idx = cyc;
    cyc++;
    sb_q.push_back(e);
    if (!s.rst) begin
      if (lw && !ms && m_lu < CMAX) m_lu++;
      if (ms && !m_err && m_mw < CMAX) m_mw++;
      if (m_err) begin
        if (s.errclr) m_err = 0;
      end else if (m_wait > 0) begin
        if (s.rdy) m_wait = 0;
        else if (m_wait == T) begin m_err = 1; m_wait = 0; end
        else m_wait++;
      end else if (s.memreq && !s.rdy) begin
        m_wait = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Monitor: outputs settle after the negedge drive; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ForwardAE", e.idx, {14'd0, ForwardAE}, {14'd0, e.fa});
        chk("ForwardBE", e.idx, {14'd0, ForwardBE}, {14'd0, e.fb});
        chk("stall_flush", e.idx, {9'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {9'd0, e.sf});
        chk("MemErr", e.idx, {15'd0, MemErr}, {15'd0, e.merr});
        chk("LoadUseCnt", e.idx, {12'd0, LoadUseCnt}, 16'(e.lu));
        chk("MemWaitCnt", e.idx, {12'd0, MemWaitCnt}, 16'(e.mw));
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1;
    apply(s); apply(s);

    s = idle(); s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5;
    apply(s);
    s.rwm = 0; apply(s);
    s.rdm = 0; s.rdw = 0; apply(s);
    s = idle(); s.rdw = 9; s.rww = 1; s.rs2e = 9; s.rdm = 9; s.rs1e = 9; apply(s);

    s = idle(); s.ld = 1; s.rde = 7; s.rs2d = 7; apply(s);
    s.rde = 0; apply(s);
    s = idle(); s.pcsrc = 1; apply(s);

    s = idle(); s.memreq = 1;
    repeat (3) apply(s);
    s.rdy = 1; apply(s);
    s = idle(); s.memreq = 1; s.pcsrc = 1;
    repeat (3) apply(s);
    s.rdy = 1; apply(s);
    s = idle(); apply(s);

    s = idle(); s.memreq = 1;
    repeat (7) apply(s);
    s = idle(); s.errclr = 1; apply(s);
    s.errclr = 0; apply(s);

    s = idle(); s.ld = 1; s.rde = 3; s.rs1d = 3;
    repeat (20) apply(s);

    s = idle(); s.memreq = 1;
    repeat (2) apply(s);
    s.memreq = 0; apply(s);
    s.rst = 1; apply(s);
    s.rst = 0; apply(s);

    repeat (3000) begin
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde = 5'($urandom_range(0, 3)); s.rdm = 5'($urandom_range(0, 3)); s.rdw = 5'($urandom_range(0, 3));
      s.rwm = $urandom_range(0, 1) == 1; s.rww = $urandom_range(0, 1) == 1;
      s.ld = $urandom_range(0, 2) == 0; s.pcsrc = $urandom_range(0, 3) == 0;
      s.memreq = $urandom_range(0, 9) < 3; s.rdy = $urandom_range(0, 9) < 3;
      s.errclr = $urandom_range(0, 9) == 0; s.rst = $urandom_range(0, 99) == 0;
      if (s.rst) s.memreq = 0;
      apply(s);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #5;
    n_checks++;
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
